// File: rtl/feature_framer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : feature_framer_pkg
// Description : Shared definitions for the feature framer and the decision
//               tree: the common data width and the framer FSM state
//               encodings.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package feature_framer_pkg;

    // Width of every feature and result word exchanged with the tree.
    localparam int c_DATA_WIDTH = 8;

    // Framer states, explicitly two bits wide.
    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_LAUNCH  = 2'd1,
        ST_WAIT    = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/feature_framer_if.sv
`default_nettype none
// ============================================================================
// Module      : feature_framer_if
// Description : Bundles the framer's sample stream, feature/launch outputs,
//               decision tree result input and framed-result handshake.
// Ports       : slave  - the framer's view (drives s_ready, features,
//                        start, result, busy)
//               master - the surrounding environment's view
// Revision    : 1.0 - initial release
// ============================================================================
interface feature_framer_if
    import feature_framer_pkg::*;
#(
    parameter int DATA_W = c_DATA_WIDTH
);
    logic [DATA_W-1:0] s_data_i;
    logic              s_valid_i;
    logic              s_ready_o;
    logic [DATA_W-1:0] x1_o;
    logic [DATA_W-1:0] x2_o;
    logic [DATA_W-1:0] x3_o;
    logic              start_o;
    logic [DATA_W-1:0] y_i;
    logic              y_valid_i;
    logic [DATA_W-1:0] r_data_o;
    logic              r_valid_o;
    logic              r_ready_i;
    logic              r_timeout_o;
    logic              busy_o;

    modport slave (
        input  s_data_i, s_valid_i, y_i, y_valid_i, r_ready_i,
        output s_ready_o, x1_o, x2_o, x3_o, start_o,
               r_data_o, r_valid_o, r_timeout_o, busy_o
    );

    modport master (
        output s_data_i, s_valid_i, y_i, y_valid_i, r_ready_i,
        input  s_ready_o, x1_o, x2_o, x3_o, start_o,
               r_data_o, r_valid_o, r_timeout_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/feature_framer_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : feature_framer_wait_timer
// Description : Cycle counter for the framer's WAIT state. Expires when the
//               count reaches TIMEOUT-1, i.e. during the TIMEOUT-th enabled
//               cycle after a clear.
// Ports       : clock, reset - clock / synchronous active-high reset
//               i_clear      - zero the count
//               i_enable     - count this cycle
//               o_expire     - count equals TIMEOUT-1
// Revision    : 1.0 - initial release
// ============================================================================
module feature_framer_wait_timer #(
    parameter int TIMEOUT = 64
) (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic i_clear,
    input  wire logic i_enable,
    output logic      o_expire
);
    localparam logic [7:0] c_LAST = 8'(TIMEOUT - 1);

    logic [7:0] r_count;

    // Count saturates at the expiry value so it can never wrap.
    always_ff @(posedge clock) begin
        if (reset || i_clear) begin
            r_count <= 8'd0;
        end else if (i_enable && !o_expire) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign o_expire = (r_count == c_LAST);
endmodule
`default_nettype wire

// File: rtl/feature_framer.sv
`default_nettype none
// ============================================================================
// Module      : feature_framer
// Description : Collects three feature samples, launches the decision tree
//               with a one-cycle start pulse, waits for its class result (or
//               a timeout) and holds the framed result until consumed.
// Ports       : clock, reset - clock / synchronous active-high reset
//               bus          - feature_framer_if.slave (sample stream,
//                              features, start, tree result, framed result,
//                              busy)
// Revision    : 1.0 - initial release
// ============================================================================
module feature_framer
    import feature_framer_pkg::*;
#(
    parameter int DATA_W  = c_DATA_WIDTH,
    parameter int TIMEOUT = 64
) (
    input  wire logic       clock,
    input  wire logic       reset,
    feature_framer_if.slave bus
);
    state_t            r_state;
    state_t            w_state_next;
    logic [1:0]        r_count;
    logic [DATA_W-1:0] r_x1;
    logic [DATA_W-1:0] r_x2;
    logic [DATA_W-1:0] r_x3;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_timeout;

    logic w_accept;
    logic w_done_real;
    logic w_done_timeout;
    logic w_expire;

    feature_framer_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clock    (clock),
        .reset    (reset),
        .i_clear  (r_state == ST_LAUNCH),
        .i_enable (r_state == ST_WAIT),
        .o_expire (w_expire)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and per-cycle event decode.
    always_comb begin
        w_state_next   = r_state;
        w_accept       = 1'b0;
        w_done_real    = 1'b0;
        w_done_timeout = 1'b0;
        case (r_state)
            ST_COLLECT: begin
                if (bus.s_valid_i) begin
                    w_accept = 1'b1;
                    if (r_count == 2'd2) begin
                        w_state_next = ST_LAUNCH;
                    end
                end
            end
            ST_LAUNCH: begin
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // A real result beats a coincident timer expiry.
                if (bus.y_valid_i) begin
                    w_done_real  = 1'b1;
                    w_state_next = ST_HOLD;
                end else if (w_expire) begin
                    w_done_timeout = 1'b1;
                    w_state_next   = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // r_valid is always set while holding.
                if (bus.r_ready_i) begin
                    w_state_next = ST_COLLECT;
                end
            end
            default: begin
                w_state_next = ST_COLLECT;
            end
        endcase
    end

    // Feature and result registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count   <= 2'd0;
            r_x1      <= '0;
            r_x2      <= '0;
            r_x3      <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (w_accept) begin
                case (r_count)
                    2'd0:    r_x1 <= bus.s_data_i;
                    2'd1:    r_x2 <= bus.s_data_i;
                    default: r_x3 <= bus.s_data_i;
                endcase
                r_count <= (r_count == 2'd2) ? 2'd0 : r_count + 2'd1;
            end
            if (w_done_real) begin
                r_data    <= bus.y_i;
                r_timeout <= 1'b0;
                r_valid   <= 1'b1;
            end else if (w_done_timeout) begin
                r_data    <= '0;
                r_timeout <= 1'b1;
                r_valid   <= 1'b1;
            end else if (r_state == ST_HOLD && bus.r_ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.s_ready_o   = (r_state == ST_COLLECT);
    assign bus.start_o     = (r_state == ST_LAUNCH);
    assign bus.busy_o      = !((r_state == ST_COLLECT) && (r_count == 2'd0));
    assign bus.x1_o        = r_x1;
    assign bus.x2_o        = r_x2;
    assign bus.x3_o        = r_x3;
    assign bus.r_data_o    = r_data;
    assign bus.r_valid_o   = r_valid;
    assign bus.r_timeout_o = r_timeout;
endmodule
`default_nettype wire

// File: tb/tb_feature_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_feature_framer
// Description : Directed self-checking bench for feature_framer: normal
//               frame, gapped samples, timeout, held result with
//               back-pressure, mid-frame reset and result/expiry race.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_feature_framer;
    import feature_framer_pkg::*;

    localparam int c_TIMEOUT = 64;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   start_cnt;
    int   start_base;

    feature_framer_if #(.DATA_W(8)) bus ();

    feature_framer #(
        .DATA_W  (8),
        .TIMEOUT (c_TIMEOUT)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts start pulses as seen at each rising edge.
    always @(posedge clk) begin
        if (bus.start_o === 1'b1) start_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one accepted sample through COLLECT.
    task automatic send(input logic [7:0] d);
        bus.s_valid_i = 1'b1;
        bus.s_data_i  = d;
        tick();
        bus.s_valid_i = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        start_cnt = 0;
        rst            = 1'b1;
        bus.s_data_i   = '0;
        bus.s_valid_i  = 1'b0;
        bus.y_i        = '0;
        bus.y_valid_i  = 1'b0;
        bus.r_ready_i  = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_s_ready", 32'(bus.s_ready_o), 32'd1);
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_start", 32'(bus.start_o), 32'd0);
        chk("rst_r_valid", 32'(bus.r_valid_o), 32'd0);
        chk("rst_x1", 32'(bus.x1_o), 32'd0);
        chk("rst_r_data", 32'(bus.r_data_o), 32'd0);

        // Back-to-back frame 1,4,7 with result 3 in the first WAIT cycle
        start_base = start_cnt;
        bus.s_valid_i = 1'b1;
        bus.s_data_i  = 8'd1; tick();
        chk("f1_busy", 32'(bus.busy_o), 32'd1);
        bus.s_data_i  = 8'd4; tick();
        bus.s_data_i  = 8'd7; tick();
        bus.s_valid_i = 1'b0;
        chk("f1_start", 32'(bus.start_o), 32'd1);
        chk("f1_s_ready_launch", 32'(bus.s_ready_o), 32'd0);
        chk("f1_x1", 32'(bus.x1_o), 32'd1);
        chk("f1_x2", 32'(bus.x2_o), 32'd4);
        chk("f1_x3", 32'(bus.x3_o), 32'd7);
        tick();
        chk("f1_start_off", 32'(bus.start_o), 32'd0);
        bus.y_valid_i = 1'b1;
        bus.y_i       = 8'd3;
        tick();
        bus.y_valid_i = 1'b0;
        chk("f1_r_valid", 32'(bus.r_valid_o), 32'd1);
        chk("f1_r_data", 32'(bus.r_data_o), 32'd3);
        chk("f1_r_timeout", 32'(bus.r_timeout_o), 32'd0);
        chk("f1_x1_hold", 32'(bus.x1_o), 32'd1);
        bus.r_ready_i = 1'b1;
        tick();
        bus.r_ready_i = 1'b0;
        chk("f1_r_valid_clr", 32'(bus.r_valid_o), 32'd0);
        chk("f1_idle", 32'(bus.busy_o), 32'd0);
        chk("f1_start_count", 32'(start_cnt - start_base), 32'd1);

        // Gapped samples 10,_,20,_,30
        start_base = start_cnt;
        send(8'd10);
        tick();
        send(8'd20);
        tick();
        chk("gap_no_start", 32'(bus.start_o), 32'd0);
        send(8'd30);
        chk("gap_start", 32'(bus.start_o), 32'd1);
        chk("gap_x1", 32'(bus.x1_o), 32'd10);
        chk("gap_x2", 32'(bus.x2_o), 32'd20);
        chk("gap_x3", 32'(bus.x3_o), 32'd30);
        tick();
        bus.y_valid_i = 1'b1;
        bus.y_i       = 8'd5;
        tick();
        bus.y_valid_i = 1'b0;
        chk("gap_r_data", 32'(bus.r_data_o), 32'd5);
        bus.r_ready_i = 1'b1;
        tick();
        bus.r_ready_i = 1'b0;
        chk("gap_start_count", 32'(start_cnt - start_base), 32'd1);

        // Timeout: no y_valid, result on 65th cycle after LAUNCH
        send(8'd1);
        send(8'd2);
        send(8'd3);
        chk("to_launch", 32'(bus.start_o), 32'd1);
        for (int i = 0; i < c_TIMEOUT; i++) tick();
        chk("to_not_yet", 32'(bus.r_valid_o), 32'd0);
        tick();
        chk("to_r_valid", 32'(bus.r_valid_o), 32'd1);
        chk("to_r_timeout", 32'(bus.r_timeout_o), 32'd1);
        chk("to_r_data", 32'(bus.r_data_o), 32'd0);

        // Back-pressure in HOLD with samples offered
        bus.s_valid_i = 1'b1;
        bus.s_data_i  = 8'h55;
        for (int i = 0; i < 10; i++) begin
            chk("bp_s_ready", 32'(bus.s_ready_o), 32'd0);
            chk("bp_r_valid", 32'(bus.r_valid_o), 32'd1);
            chk("bp_r_timeout", 32'(bus.r_timeout_o), 32'd1);
            tick();
        end
        chk("bp_x1_unchanged", 32'(bus.x1_o), 32'd1);
        bus.r_ready_i = 1'b1;
        tick();
        bus.r_ready_i = 1'b0;
        chk("bp_resume_ready", 32'(bus.s_ready_o), 32'd1);
        chk("bp_r_valid_clr", 32'(bus.r_valid_o), 32'd0);
        tick();
        bus.s_valid_i = 1'b0;
        chk("bp_accept_x1", 32'(bus.x1_o), 32'h55);

        // Reset after 2nd sample, then frame 5,6,7
        send(8'h66);
        chk("mr_busy", 32'(bus.busy_o), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_x1_clr", 32'(bus.x1_o), 32'd0);
        chk("mr_idle", 32'(bus.busy_o), 32'd0);
        chk("mr_s_ready", 32'(bus.s_ready_o), 32'd1);
        start_base = start_cnt;
        send(8'd5);
        send(8'd6);
        chk("mr_no_start_early", 32'(start_cnt - start_base), 32'd0);
        send(8'd7);
        chk("mr_x1", 32'(bus.x1_o), 32'd5);
        chk("mr_x2", 32'(bus.x2_o), 32'd6);
        chk("mr_x3", 32'(bus.x3_o), 32'd7);
        // y_valid during LAUNCH must be ignored
        bus.y_valid_i = 1'b1;
        bus.y_i       = 8'hAA;
        tick();
        bus.y_valid_i = 1'b0;
        chk("mr_launch_y_ignored", 32'(bus.r_valid_o), 32'd0);
        chk("mr_start_count", 32'(start_cnt - start_base), 32'd1);

        // Result 9 coincident with timer expiry (64th WAIT cycle)
        for (int i = 0; i < c_TIMEOUT - 1; i++) tick();
        chk("race_not_yet", 32'(bus.r_valid_o), 32'd0);
        bus.y_valid_i = 1'b1;
        bus.y_i       = 8'd9;
        tick();
        bus.y_valid_i = 1'b0;
        chk("race_r_valid", 32'(bus.r_valid_o), 32'd1);
        chk("race_r_data", 32'(bus.r_data_o), 32'd9);
        chk("race_r_timeout", 32'(bus.r_timeout_o), 32'd0);
        bus.r_ready_i = 1'b1;
        tick();
        bus.r_ready_i = 1'b0;
        chk("race_done", 32'(bus.s_ready_o), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/feature_framer.md
FEATURE_FRAMER -- requirements
Module: feature_framer

Interface
REQ-001 Parameter DATA_W, default 8, width of every feature and result word; equals the shared DataWidth definition.
REQ-002 Parameter TIMEOUT, default 64, maximum WAIT cycles before the frame is abandoned; legal range 2..255.
REQ-003 clock  in  1  single clock, rising-edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 s_data_i  in  DATA_W  feature sample stream.
REQ-006 s_valid_i  in  1  sample present.
REQ-007 s_ready_o  out  1  framer accepts sample.
REQ-008 x1_o, x2_o, x3_o  out  DATA_W each  feature vector to decision tree.
REQ-009 start_o  out  1  one-cycle launch pulse to decision tree.
REQ-010 y_i  in  DATA_W  decision tree class output.
REQ-011 y_valid_i  in  1  decision tree result valid.
REQ-012 r_data_o  out  DATA_W  framed result.
REQ-013 r_valid_o  out  1  result available.
REQ-014 r_ready_i  in  1  consumer takes result.
REQ-015 r_timeout_o  out  1  result is a timeout marker, qualified by r_valid_o.
REQ-016 busy_o  out  1  high in every state except COLLECT with count 0.

Function
REQ-017 FSM states COLLECT, LAUNCH, WAIT, HOLD; one state per cycle, registered.
REQ-018 COLLECT: s_ready_o=1; sample accepted when s_valid_i&s_ready_o; 1st accept -> x1_o, 2nd -> x2_o, 3rd -> x3_o; 2-bit count tracks accepts.
REQ-019 3rd accept at edge N -> state LAUNCH, start_o=1 for exactly the cycle after N, count cleared.
REQ-020 s_ready_o=0 in LAUNCH, WAIT, HOLD; s_valid_i ignored there.
REQ-021 x1_o..x3_o hold stable from LAUNCH until the next frame's 1st accept overwrites x1_o.
REQ-022 LAUNCH -> WAIT unconditionally; WAIT timer cleared on entry.
REQ-023 WAIT: y_valid_i=1 -> r_data_o<=y_i, r_timeout_o<=0, r_valid_o<=1, state HOLD next cycle.
REQ-024 WAIT: timer increments each cycle; at TIMEOUT-1 with y_valid_i=0 -> r_data_o<=0, r_timeout_o<=1, r_valid_o<=1, state HOLD.
REQ-025 y_valid_i in the same cycle the timer reaches TIMEOUT-1: real result wins, r_timeout_o=0.
REQ-026 y_valid_i in COLLECT, LAUNCH or HOLD ignored; no state or output change.
REQ-027 HOLD: r_valid_o, r_data_o, r_timeout_o stable until r_valid_o&r_ready_i; that edge -> COLLECT, r_valid_o<=0.
REQ-028 r_ready_i outside HOLD has no effect.
REQ-029 Minimum frame-to-result latency: result visible 3 cycles after 3rd accept when y_valid_i arrives the first WAIT cycle.

Reset
REQ-030 reset=1 at a rising edge: state COLLECT, count 0, timer 0, all outputs 0, s_ready_o=1 from the following cycle.
REQ-031 Reset mid-frame (any state) discards partial features and pending result; no start_o or r_valid_o after reset until a new 3-sample frame.

Structure
REQ-032 DataWidth definition and FSM state encodings live in the shared definitions header included by decision_tree and feature_framer.
REQ-033 WAIT timer is one sub-module wait_timer (clear, enable, expire at TIMEOUT-1); all else in feature_framer.

Verification
REQ-034 Samples 1,4,7 back-to-back, y_i=3 with y_valid_i one cycle after start_o -> x1_o=1,x2_o=4,x3_o=7, single start_o pulse, r_data_o=3, r_timeout_o=0.
REQ-035 s_valid_i gapped (samples 10,_,20,_,30) -> exactly three accepts, start_o one cycle after 30 accepted.
REQ-036 No y_valid_i, TIMEOUT=64 -> r_valid_o=1, r_timeout_o=1, r_data_o=0 on 65th cycle after LAUNCH.
REQ-037 r_ready_i=0 for 10 cycles in HOLD, s_valid_i=1 -> s_ready_o=0, result held, accept resumes the cycle after r_ready_i=1.
REQ-038 reset after 2nd sample, then samples 5,6,7 -> x1_o=5,x2_o=6,x3_o=7, one start_o.
REQ-039 y_valid_i=1 with y_i=9 coincident with timer expiry -> r_data_o=9, r_timeout_o=0.
